// File: rtl/bus_pkg.sv
// Shared bus definitions: widths, direction encoding, master FSM states and command record.
package bus_pkg;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 8;

  localparam logic BUS_RD = 1'b0;
  localparam logic BUS_WR = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    XFER,
    RDWAIT,
    DONE
  } bmp_state_t;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_cmd_t;

endpackage

// File: rtl/bus_master_port.sv
// Initiator-side bus agent: turns local single-beat commands into request/grant bus
// transactions, keeping the grant across back-to-back commands up to MAX_HOLD beats.
module bus_master_port #(
  parameter int unsigned ADDR_W   = bus_pkg::ADDR_W,
  parameter int unsigned DATA_W   = bus_pkg::DATA_W,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              grant_request,
  input  logic              grant_given,
  output logic              rw,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_out,
  input  logic [DATA_W-1:0] data_in
);
  import bus_pkg::*;

  localparam int unsigned      CNT_W    = 2;
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(RD_LAT - 1);
  localparam logic [3:0]       HOLD_LIM = 4'(MAX_HOLD);

  bmp_state_t        state_q, state_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [3:0]        beats_q, beats_d;
  logic [CNT_W-1:0]  lat_q, lat_d;
  logic              abort_q, abort_d;
  logic              err_q, err_d;

  logic              bus_act;
  logic              accept;
  logic [3:0]        beat_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      beats_q <= '0;
      lat_q   <= '0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      beats_q <= beats_d;
      lat_q   <= lat_d;
      abort_q <= abort_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    beats_d   = beats_q;
    lat_d     = lat_q;
    abort_d   = abort_q;
    err_d     = err_q;
    cmd_ready = 1'b0;
    beat_inc  = (beats_q == HOLD_LIM) ? beats_q : beats_q + 4'd1;

    // Holding in DONE compares the post-increment count so the MAX_HOLD-th beat releases.
    if (!reset) begin
      if (state_q == IDLE) begin
        cmd_ready = 1'b1;
      end else if (state_q == DONE && !abort_q &&
                   ({1'b0, beats_q} + 5'd1) < {1'b0, HOLD_LIM}) begin
        cmd_ready = 1'b1;
      end
    end
    accept = cmd_valid && cmd_ready;

    if (accept) begin
      rw_d    = cmd_rw;
      addr_d  = cmd_addr;
      wdata_d = cmd_wdata;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          abort_d = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (grant_given) state_d = XFER;
      end
      XFER: begin
        if (!grant_given) begin
          abort_d = 1'b1;
          err_d   = 1'b1;
        end
        if (rw_q == BUS_WR) begin
          state_d = DONE;
        end else begin
          lat_d   = LAT_INIT;
          state_d = RDWAIT;
        end
      end
      RDWAIT: begin
        if (!grant_given) begin
          abort_d = 1'b1;
          err_d   = 1'b1;
        end
        if (lat_q == '0) begin
          rdata_d = data_in;
          state_d = DONE;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      DONE: begin
        if (accept) begin
          beats_d = beat_inc;
          state_d = XFER;
        end else begin
          beats_d = '0;
          abort_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs are forced to zero whenever this port is not actively driving.
  assign bus_act       = (state_q == XFER) || (state_q == RDWAIT);
  assign address       = bus_act ? addr_q : '0;
  assign rw            = bus_act ? rw_q : 1'b0;
  assign data_out      = (bus_act && rw_q == BUS_WR) ? wdata_q : '0;
  assign grant_request = (state_q != IDLE);
  assign rsp_valid     = (state_q == DONE);
  assign rsp_rdata     = rdata_q;

endmodule

// File: tb/tb_bus_master_port.sv
// Scoreboard bench for bus_master_port: a bench-side arbiter/slave drives grant and read
// data; expected bus beats, responses and grant spans are queued at acceptance.
module tb_bus_master_port;

  localparam int unsigned RD_LAT   = 2;
  localparam int unsigned MAX_HOLD = 4;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rw;
  logic [8:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       grant_request;
  logic       grant_given;
  logic       rw;
  logic [8:0] address;
  logic [7:0] data_out;
  logic [7:0] data_in;

  bus_master_port #(
    .ADDR_W  (9),
    .DATA_W  (8),
    .RD_LAT  (RD_LAT),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_rw       (cmd_rw),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .grant_request(grant_request),
    .grant_given  (grant_given),
    .rw           (rw),
    .address      (address),
    .data_out     (data_out),
    .data_in      (data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks;
  int errors;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] rdata;
    int         acc;
    int         lat;
  } rsp_t;

  typedef struct {
    logic       rw;
    logic [8:0] addr;
    logic [7:0] dout;
  } xfer_t;

  rsp_t  rsp_q[$];
  xfer_t bus_q[$];
  int    span_q[$];

  int         gnt_delay;
  bit         kill_en;
  logic [7:0] rd_value;
  logic [7:0] last_rd;

  // Bench-side arbiter, read slave and output monitor, all evaluated on the falling edge.
  initial begin : mon
    int    age;
    bit    xrw;
    bit    prev_idle;
    bit    prev_req;
    bit    killed;
    bit    busy;
    int    span;
    int    req_age;
    xfer_t x;
    rsp_t  r;
    age = 255; xrw = 1'b0; prev_idle = 1'b1; prev_req = 1'b0; killed = 1'b0;
    span = 0; req_age = 0;
    grant_given = 1'b0;
    data_in = 8'hEE;
    forever begin
      @(negedge clk);
      busy = (address != 9'd0) || rw;
      if (busy && prev_idle) begin
        age = 0;
        xrw = rw;
        if (bus_q.size() == 0) begin
          check_eq("xfer_unexpected", 1, 0);
        end else begin
          x = bus_q.pop_front();
          check_eq("xfer_addr", 32'(address), 32'(x.addr));
          check_eq("xfer_rw", 32'(rw), 32'(x.rw));
          check_eq("xfer_dout", 32'(data_out), 32'(x.dout));
        end
      end else if (busy) begin
        if (age < 255) age++;
      end else begin
        age = 255;
      end
      prev_idle = !busy;
      data_in = (busy && !xrw && age == int'(RD_LAT)) ? rd_value : 8'hEE;

      if (!grant_request) begin
        grant_given = 1'b0;
        req_age = 0;
        killed = 1'b0;
      end else begin
        if (kill_en && busy && !xrw && age == 1) begin
          killed = 1'b1;
          kill_en = 1'b0;
        end
        grant_given = !killed && (req_age >= gnt_delay);
        req_age++;
      end

      if (grant_request && !prev_req) span = 0;
      if (rsp_valid) begin
        span++;
        check_eq("bus_idle_in_done", 32'({rw, address, data_out}), 0);
        if (rsp_q.size() == 0) begin
          check_eq("rsp_unexpected", 1, 0);
        end else begin
          r = rsp_q.pop_front();
          check_eq("rsp_rdata", 32'(rsp_rdata), 32'(r.rdata));
          check_eq("rsp_latency", cyc - r.acc, r.lat);
        end
      end
      if (!grant_request && prev_req) begin
        if (span_q.size() == 0) check_eq("span_unexpected", 1, 0);
        else check_eq("grant_span_beats", span, span_q.pop_front());
      end
      prev_req = grant_request;
    end
  end

  task automatic issue(input logic rw_i, input logic [8:0] a, input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_rw    = rw_i;
    cmd_addr  = a;
    cmd_wdata = d;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        rsp_t  r;
        xfer_t x;
        if (!rw_i) last_rd = rd_value;
        r.rdata = last_rd;
        r.acc   = cyc;
        r.lat   = (rsp_valid ? 2 : 3 + gnt_delay) + (rw_i ? 0 : int'(RD_LAT));
        rsp_q.push_back(r);
        x.rw   = rw_i;
        x.addr = a;
        x.dout = rw_i ? d : 8'h00;
        bus_q.push_back(x);
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (!ok) check_eq("accept_timeout", 0, 1);
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (rsp_q.size() == 0 && bus_q.size() == 0 && span_q.size() == 0 && !grant_request) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check_eq({tag, "_drain_timeout"}, 0, 1);
  endtask

  initial begin : main
    bit seen;
    checks = 0; errors = 0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    gnt_delay = 0; kill_en = 1'b0; rd_value = 8'h00; last_rd = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_outputs",
             32'({grant_request, rsp_valid, rw, address, data_out, rsp_rdata, cmd_ready}), 0);
    reset = 1'b0;
    #1;
    check_eq("rst_ready_after", 32'(cmd_ready), 1);

    // Reset while waiting for a grant that never comes.
    gnt_delay = 1000;
    span_q.push_back(0);
    issue(1'b1, 9'h011, 8'hAA);
    repeat (3) @(posedge clk);
    #1;
    check_eq("t1_req_held", 32'(grant_request), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("t1_rst_outputs", 32'({grant_request, rsp_valid, rw, address, data_out}), 0);
    check_eq("t1_ready_in_rst", 32'(cmd_ready), 0);
    reset = 1'b0;
    rsp_q.delete();
    bus_q.delete();
    #1;
    check_eq("t1_ready_after", 32'(cmd_ready), 1);
    drain("t1");

    // Single write with a delayed grant.
    gnt_delay = 2;
    span_q.push_back(1);
    issue(1'b1, 9'h1F0, 8'h5A);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("t2_rsp_seen", 32'(seen), 1);
    @(posedge clk);
    #1;
    check_eq("t2_req_drop", 32'(grant_request), 0);
    drain("t2");

    // Single read with the data held afterwards.
    gnt_delay = 0;
    rd_value = 8'hC3;
    span_q.push_back(1);
    issue(1'b0, 9'h004, 8'h00);
    drain("t3");
    repeat (5) @(posedge clk);
    #1;
    check_eq("t3_rdata_held", 32'(rsp_rdata), 32'h0C3);

    // Six back-to-back writes split into MAX_HOLD beats then the remainder.
    gnt_delay = 1;
    span_q.push_back(4);
    span_q.push_back(2);
    for (int i = 0; i < 6; i++) begin
      issue(1'b1, 9'(9'h100 + i), 8'(8'h10 + 3 * i));
    end
    drain("t4");
    check_eq("t4_err_clear", 32'(dut.err_q), 0);

    // Grant withdrawn mid-read, followed by a write that must re-arbitrate.
    gnt_delay = 0;
    kill_en = 1'b1;
    rd_value = 8'h3C;
    span_q.push_back(1);
    span_q.push_back(1);
    issue(1'b0, 9'h0A5, 8'h00);
    issue(1'b1, 9'h0A6, 8'h77);
    drain("t5");
    check_eq("t5_kill_fired", 32'(kill_en), 0);
    check_eq("t5_err_sticky", 32'(dut.err_q), 1);

    // Quiet bus.
    repeat (50) begin
      @(posedge clk);
      #1;
      check_eq("t6_idle_bus", 32'({grant_request, rw, address, data_out}), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
